// File: rtl/operand_bypass_if.sv
// Operand bypass bus: pipeline control, issue info, stage results and read ports in,
// bypassed operands and hazard status out.
interface operand_bypass_if #(
    parameter int N_READ  = 2,
    parameter int N_STAGE = 3,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
);
    localparam int AV_W = $clog2(N_STAGE + 1);

    logic                        advance;
    logic [N_STAGE-1:0]          flush;
    logic                        issue_wen;
    logic [REG_W-1:0]            issue_dst;
    logic [AV_W-1:0]             issue_avail;
    logic [N_STAGE*DATA_W-1:0]   stage_data;
    logic [N_READ-1:0]           rd_en;
    logic [N_READ*REG_W-1:0]     rd_addr;
    logic [N_READ*DATA_W-1:0]    rf_data;
    logic [N_READ*DATA_W-1:0]    operand;
    logic [N_READ-1:0]           fwd_hit;
    logic                        stall;
    logic [CNT_W-1:0]            stall_cnt;

    modport master (
        output advance, flush, issue_wen, issue_dst, issue_avail,
        output stage_data, rd_en, rd_addr, rf_data,
        input  operand, fwd_hit, stall, stall_cnt
    );

    modport slave (
        input  advance, flush, issue_wen, issue_dst, issue_avail,
        input  stage_data, rd_en, rd_addr, rf_data,
        output operand, fwd_hit, stall, stall_cnt
    );
endinterface

// File: rtl/operand_bypass.sv
// ID-stage operand bypass and hazard unit: a tag pipe mirrors EX..WB destinations and
// each read port picks the youngest matching producer, stalling if it is not ready yet.
module operand_bypass_port #(
    parameter int N_STAGE = 3,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int AV_W    = 2
) (
    input  logic [N_STAGE-1:0]             vld,
    input  logic [N_STAGE-1:0][REG_W-1:0]  dst,
    input  logic [N_STAGE-1:0][AV_W-1:0]   avail,
    input  logic [N_STAGE-1:0][DATA_W-1:0] stage_data,
    input  logic                           rd_en,
    input  logic [REG_W-1:0]               rd_addr,
    input  logic [DATA_W-1:0]              rf_data,
    output logic [DATA_W-1:0]              operand,
    output logic                           fwd_hit,
    output logic                           hazard
);
    logic              hit;
    logic [AV_W-1:0]   sel;
    logic [AV_W-1:0]   sel_av;
    logic [DATA_W-1:0] sel_data;
    logic              active;
    logic              ready;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        sel_av   = '0;
        sel_data = '0;
        for (int k = N_STAGE - 1; k >= 0; k--) begin
            if (vld[k] && dst[k] == rd_addr) begin
                hit      = 1'b1;
                sel      = AV_W'(k);
                sel_av   = avail[k];
                sel_data = stage_data[k];
            end
        end
    end

    assign active  = hit && rd_en && (rd_addr != '0);
    assign ready   = (sel >= sel_av);
    assign fwd_hit = active && ready;
    assign hazard  = active && !ready;
    assign operand = fwd_hit ? sel_data : rf_data;
endmodule

module operand_bypass #(
    parameter int N_READ  = 2,
    parameter int N_STAGE = 3,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_bypass_if.slave  bus
);
    localparam int AV_W = $clog2(N_STAGE + 1);

    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic [AV_W-1:0]  avail;
    } tag_t;

    logic [N_STAGE-1:0]             vld_pipe;
    logic [N_STAGE-1:0]             vld_nxt;
    tag_t [N_STAGE-1:0]             tag_pipe;
    tag_t [N_STAGE-1:0]             tag_nxt;
    logic [N_STAGE-1:0][REG_W-1:0]  dst_a;
    logic [N_STAGE-1:0][AV_W-1:0]   av_a;
    logic [N_STAGE-1:0][DATA_W-1:0] stage_d;
    logic [N_READ-1:0][REG_W-1:0]   rd_addr;
    logic [N_READ-1:0][DATA_W-1:0]  rf_data;
    logic [N_READ-1:0][DATA_W-1:0]  operand;
    logic [N_READ-1:0]              hazard;
    logic                           stall;
    logic                           issue_vld;
    logic [CNT_W-1:0]               stall_cnt;

    assign stage_d = bus.stage_data;
    assign rd_addr = bus.rd_addr;
    assign rf_data = bus.rf_data;

    genvar k, i;
    generate
        for (k = 0; k < N_STAGE; k++) begin : g_tag
            assign dst_a[k] = tag_pipe[k].dst;
            assign av_a[k]  = tag_pipe[k].avail;
        end

        for (i = 0; i < N_READ; i++) begin : g_port
            operand_bypass_port #(
                .N_STAGE (N_STAGE),
                .DATA_W  (DATA_W),
                .REG_W   (REG_W),
                .AV_W    (AV_W)
            ) u_port (
                .vld        (vld_pipe),
                .dst        (dst_a),
                .avail      (av_a),
                .stage_data (stage_d),
                .rd_en      (bus.rd_en[i]),
                .rd_addr    (rd_addr[i]),
                .rf_data    (rf_data[i]),
                .operand    (operand[i]),
                .fwd_hit    (bus.fwd_hit[i]),
                .hazard     (hazard[i])
            );
        end
    endgenerate

    assign stall         = |hazard;
    assign bus.stall     = stall;
    assign bus.operand   = operand;
    assign bus.stall_cnt = stall_cnt;

    // A stalled ID instruction enters EX as a bubble; r0 writes are never tracked.
    assign issue_vld = bus.issue_wen && !stall && (bus.issue_dst != '0);

    always_comb begin
        vld_nxt = vld_pipe;
        tag_nxt = tag_pipe;
        if (bus.advance) begin
            vld_nxt[0] = issue_vld;
            tag_nxt[0] = '{dst: bus.issue_dst, avail: bus.issue_avail};
            for (int s = 1; s < N_STAGE; s++) begin
                vld_nxt[s] = vld_pipe[s-1];
                tag_nxt[s] = tag_pipe[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            tag_pipe  <= '0;
            stall_cnt <= '0;
        end else begin
            vld_pipe <= vld_nxt & ~bus.flush;
            tag_pipe <= tag_nxt;
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_operand_bypass.sv
// Bench for operand_bypass: directed scenarios plus randomized traffic checked against
// a list-of-producers reference model.
module tb_operand_bypass;
    localparam int NR   = 2;
    localparam int NS   = 3;
    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int CW   = 8;
    localparam int AVW  = $clog2(NS + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    operand_bypass_if #(.N_READ(NR), .N_STAGE(NS), .DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus ();

    operand_bypass #(.N_READ(NR), .N_STAGE(NS), .DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of in-flight producers, index 0 = youngest (EX).
    bit m_vld [NS];
    int m_dst [NS];
    int m_av  [NS];
    int m_cnt;
    bit e_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NS; k++) begin
            m_vld[k] = 1'b0;
            m_dst[k] = 0;
            m_av[k]  = 0;
        end
        m_cnt = 0;
    endtask

    task automatic idle();
        bus.advance     = 1'b1;
        bus.flush       = '0;
        bus.issue_wen   = 1'b0;
        bus.issue_dst   = '0;
        bus.issue_avail = '0;
        bus.stage_data  = {$urandom, $urandom, $urandom};
        bus.rd_en       = '0;
        bus.rd_addr     = '0;
        bus.rf_data     = {$urandom, $urandom};
    endtask

    function automatic logic [DW-1:0] sdata(input int k);
        logic [NS*DW-1:0] v;
        v = bus.stage_data;
        return v[k*DW +: DW];
    endfunction

    // Compare all outputs with what the producer list predicts at this instant.
    task automatic probe();
        logic [DW-1:0] e_op;
        logic [DW-1:0] rf;
        logic          e_hit;
        int            addr;
        int            y;
        @(negedge clk);
        e_stall = 1'b0;
        for (int i = 0; i < NR; i++) begin
            addr  = int'(bus.rd_addr[i*RW +: RW]);
            rf    = bus.rf_data[i*DW +: DW];
            e_op  = rf;
            e_hit = 1'b0;
            y     = -1;
            if (bus.rd_en[i] && addr != 0)
                for (int k = 0; k < NS; k++)
                    if (y < 0 && m_vld[k] && m_dst[k] == addr) y = k;
            if (y >= 0) begin
                if (y >= m_av[y]) begin
                    e_op  = sdata(y);
                    e_hit = 1'b1;
                end else begin
                    e_stall = 1'b1;
                end
            end
            chk($sformatf("operand%0d", i), 64'(bus.operand[i*DW +: DW]), 64'(e_op));
            chk($sformatf("fwd_hit%0d", i), 64'(bus.fwd_hit[i]), 64'(e_hit));
        end
        chk("stall", 64'(bus.stall), 64'(e_stall));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (bus.advance) begin
                for (int k = NS - 1; k > 0; k--) begin
                    m_vld[k] = m_vld[k-1];
                    m_dst[k] = m_dst[k-1];
                    m_av[k]  = m_av[k-1];
                end
                m_vld[0] = bus.issue_wen && !e_stall && bus.issue_dst != 0;
                m_dst[0] = int'(bus.issue_dst);
                m_av[0]  = int'(bus.issue_avail);
            end
            for (int k = 0; k < NS; k++)
                if (bus.flush[k]) m_vld[k] = 1'b0;
            if (e_stall && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        idle();
        probe();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input int dst, input int av);
        bus.issue_wen   = 1'b1;
        bus.issue_dst   = RW'(dst);
        bus.issue_avail = AVW'(av);
    endtask

    initial begin
        rst_n = 1'b1;
        model_clear();
        idle();
        #2;

        // Reset state
        rst_n = 1'b0;
        model_clear();
        bus.rd_en   = 2'b01;
        bus.rd_addr = {RW'(0), RW'(5)};
        bus.rf_data = {32'h0, 32'hAAAA0000};
        probe();
        chk("rst_operand", 64'(bus.operand[DW-1:0]), 64'h0000_0000_AAAA_0000);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        tick();
        rst_n = 1'b1;

        // ALU producer forwarded from EX
        idle();
        issue(5, 0);
        probe(); tick();
        idle();
        bus.rd_en      = 2'b01;
        bus.rd_addr    = {RW'(0), RW'(5)};
        bus.stage_data = {32'h0, 32'h0, 32'h12345678};
        probe();
        chk("alu_fwd_op", 64'(bus.operand[DW-1:0]), 64'h12345678);
        chk("alu_fwd_hit", 64'(bus.fwd_hit[0]), 64'd1);
        tick();

        // Youngest producer wins
        do_reset();
        idle(); issue(5, 0); probe(); tick();
        idle(); issue(5, 0); probe(); tick();
        idle();
        bus.rd_en      = 2'b11;
        bus.rd_addr    = {RW'(5), RW'(5)};
        bus.stage_data = {32'h3, 32'h2, 32'h1};
        probe();
        chk("youngest_op", 64'(bus.operand[DW-1:0]), 64'h1);
        tick();

        // Load-use: one stall, bubble, then forward from MEM
        do_reset();
        idle(); issue(7, 1); probe(); tick();
        idle();
        issue(8, 0);
        bus.rd_en   = 2'b01;
        bus.rd_addr = {RW'(0), RW'(7)};
        probe();
        chk("lu_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.stage_data = {$urandom, 32'hCAFEF00D, $urandom};
        bus.rd_en      = 2'b11;
        bus.rd_addr    = {RW'(8), RW'(7)};
        probe();
        chk("lu_fwd_op", 64'(bus.operand[DW-1:0]), 64'hCAFEF00D);
        chk("lu_unstall", 64'(bus.stall), 64'd0);
        chk("lu_bubble", 64'(bus.fwd_hit[1]), 64'd0);
        chk("lu_cnt", 64'(bus.stall_cnt), 64'd1);
        tick();

        // Flush of the EX entry on the issue edge
        do_reset();
        idle(); issue(7, 1); bus.flush = 3'b001; probe(); tick();
        idle();
        bus.rd_en   = 2'b01;
        bus.rd_addr = {RW'(0), RW'(7)};
        bus.rf_data = {32'h0, 32'h55AA55AA};
        probe();
        chk("flush_op", 64'(bus.operand[DW-1:0]), 64'h55AA55AA);
        chk("flush_stall", 64'(bus.stall), 64'd0);
        tick();

        // r0 never forwards nor stalls
        do_reset();
        idle(); issue(0, 3); probe(); tick();
        idle();
        bus.rd_en   = 2'b11;
        bus.rd_addr = {RW'(0), RW'(0)};
        probe();
        chk("r0_hit", 64'(bus.fwd_hit), 64'd0);
        chk("r0_stall", 64'(bus.stall), 64'd0);
        tick();

        // Counter saturation under a held stall
        do_reset();
        idle(); issue(9, 3); probe(); tick();
        idle();
        bus.advance = 1'b0;
        bus.rd_en   = 2'b10;
        bus.rd_addr = {RW'(9), RW'(0)};
        repeat ((1 << CW) + 3) begin probe(); tick(); end
        probe();
        chk("sat_cnt", 64'(bus.stall_cnt), 64'(CMAX));
        chk("sat_stall", 64'(bus.stall), 64'd1);
        tick();

        // Randomized traffic with occasional mid-run resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bus.advance     = ($urandom_range(0, 9) < 8);
            bus.flush       = ($urandom_range(0, 9) == 0) ? NS'($urandom) : '0;
            bus.issue_wen   = $urandom_range(0, 1);
            bus.issue_dst   = RW'($urandom_range(0, 7));
            bus.issue_avail = AVW'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            bus.stage_data  = {$urandom, $urandom, $urandom};
            bus.rd_en       = NR'($urandom);
            bus.rd_addr     = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
            bus.rf_data     = {$urandom, $urandom};
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end
            probe();
            tick();
            rst_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_bypass.md
# operand_bypass

Parametrised ID-stage operand bypass and hazard unit, successor to the two-operand branch-source multiplexer. It tracks in-flight destination registers in an internal tag pipeline that mirrors the EX..WB stages. For each of N read ports it selects the youngest ready producer's data or the register-file value. When the youngest matching producer has not yet produced its result, it raises a stall. A saturating stall-cycle counter is included for performance monitoring.

## Interface
- `N_READ`, 2, number of operand read ports
- `N_STAGE`, 3, tracked stages downstream of ID; index 0 = EX, N_STAGE-1 = WB
- `DATA_W`, 32, operand width
- `REG_W`, 5, register address width
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `advance`  in  1  pipeline moves this cycle; the tag pipe shifts
- `flush`  in  N_STAGE  per-stage kill mask, applied at the clock edge
- `issue_wen`  in  1  the instruction in ID writes a register
- `issue_dst`  in  REG_W  destination of the ID instruction
- `issue_avail`  in  $clog2(N_STAGE+1)  first stage index whose `stage_data` holds this result; 0 = ALU, 1 = load
- `stage_data`  in  N_STAGE*DATA_W  result bus per stage, flattened, with stage k at bits [k*DATA_W +: DATA_W]
- `rd_en`  in  N_READ  port i actually reads a register
- `rd_addr`  in  N_READ*REG_W  source addresses
- `rf_data`  in  N_READ*DATA_W  register-file read data
- `operand`  out  N_READ*DATA_W  bypassed operands
- `fwd_hit`  out  N_READ  port i took bypass data
- `stall`  out  1  ID must hold; a bubble is inserted
- `stall_cnt`  out  CNT_W  saturating count of stall cycles

## Operation
- Tag pipe: N_STAGE entries, each holding {valid, dst, avail}. Entry 0 is the youngest.
- On a clock edge with `advance`=1:
  - Entry k+1 takes entry k.
  - Entry 0 takes {`issue_wen` && !`stall` && `issue_dst`!=0, `issue_dst`, `issue_avail`}.
  - When `stall`=1, entry 0 becomes invalid (bubble).
- With `advance`=0 the entries hold.
- `flush` bit k clears entry k's valid bit after any shift. Flush takes precedence over the data loaded on the same edge.
- Per port i, combinationally:
  - Candidate k: valid, dst==rd_addr[i], rd_addr[i]!=0, rd_en[i]=1.
  - Select the lowest matching k (youngest).
  - If k >= avail: `operand[i]` = stage_data[k], `fwd_hit[i]`=1.
  - Otherwise, port i is hazarded and `operand[i]` = rf_data[i].
  - With no match: `operand[i]` = rf_data[i], `fwd_hit[i]`=0.
  - Older matches are never used when a younger one exists, even if that younger one is not ready.
- `stall` = OR of the per-port hazards. It is independent of `advance`.
- `stall_cnt`: increments on each edge where `stall`=1. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Register 0 never forwards and never stalls.

## Timing
- Bypass select, `operand`, `fwd_hit` and `stall` are combinational from the current tag state and inputs: zero latency.
- The tag pipe and counter update on the rising `clk` edge.
- Reset (async assert, sync-free deassert):
  - All entries are invalid and `stall_cnt`=0.
  - Consequently `stall`=0, `fwd_hit`=0, and `operand`=rf_data.
- Reset mid-operation discards all in-flight tags immediately. No stall persists.
- Load-use: a load with avail=1 in EX causes exactly one stall cycle for a dependent ID instruction, provided `advance`=1 throughout. The next cycle forwards from stage 1.
- Simultaneous flush and stall: the inserted bubble and the flushed entries are both invalid; there is no conflict.
- `stall_cnt` wrap-around is prohibited; it holds at its maximum value.

## Test plan
- Reset with `rd_addr`=5, `rf_data`=0xAAAA0000 -> `operand`=0xAAAA0000, `stall`=0, `stall_cnt`=0.
- Issue ALU write r5 (avail 0), advance once, then read r5 with stage_data[0]=0x12345678 -> operand=0x12345678, fwd_hit=1, stall=0.
- Issue r5 into EX (avail 0) and an older r5 in MEM, with stage_data[0]=0x1, stage_data[1]=0x2 -> operand=0x1 (youngest wins).
- Load r7 (avail 1) in EX, ID reads r7 -> stall=1 for one cycle, a bubble in EX, then operand=stage_data[1], stall=0, stall_cnt=1.
- Load r7 in EX with flush=3'b001 on the edge -> the entry is cleared, so the next cycle's read of r7 gives rf_data and stall=0.
- Write and read r0 -> no forward and no stall. Also hold stall for 2^CNT_W+3 cycles -> stall_cnt saturates at all-ones.
